sseg_scan_driver: RTL and testbench

//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/sseg_scan_driver.sv | 179 +++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_driver
// Purpose  : Time-multiplexed common-anode 7-segment scan driver with hex decode,
//            leading-zero blanking, PWM brightness and inter-digit dead time.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DIM_BITS   = 4,
  parameter int DEAD_CYC   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [DIM_BITS-1:0]     brightness,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int c_slot_w = $clog2(SCAN_DIV);
  localparam int c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_DIV - 1);
  localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);
  localparam logic [c_slot_w-1:0] c_dead      = c_slot_w'(DEAD_CYC);
  localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [c_idx_w-1:0]  c_idx_one   = c_idx_w'(1);
  localparam logic [DIM_BITS-1:0] c_pwm_one   = DIM_BITS'(1);
  localparam logic [6:0]          c_seg_blank = 7'h7F;

  // Scan counters
  logic [c_slot_w-1:0]     r_slot_cnt;
  logic [DIM_BITS-1:0]     r_pwm_cnt;
  logic [c_idx_w-1:0]      r_idx;

  // Frame snapshot of the display content
  logic [4*NUM_DIGITS-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_en;
  logic                    r_snap_blank_lz;

  // Registered pin outputs
  logic [6:0]              r_sseg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_tick;

  logic                    w_slot_wrap;
  logic                    w_frame_wrap;
  logic [3:0]              w_cur_nib;
  logic                    w_cur_en;
  logic                    w_cur_dp;
  logic                    w_cur_blank;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_run;
  logic                    w_lit;
  logic [6:0]              w_sseg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_slot_wrap  = (r_slot_cnt == c_slot_last);
  assign w_frame_wrap = w_slot_wrap & (r_idx == c_idx_last);

  // Per-digit attributes of the digit currently being scanned
  always_comb begin
    w_cur_nib   = 4'h0;
    w_cur_en    = 1'b0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_cur_nib   = r_snap_digits[4*i +: 4];
        w_cur_en    = r_snap_en[i];
        w_cur_dp    = r_snap_dp[i];
        w_cur_blank = w_blank[i];
      end
    end
  end

  // A digit is a leading zero when it and every more significant nibble are 0;
  // digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_snap_digits[4*i +: 4] == 4'h0);
      w_blank[i] = r_snap_blank_lz & w_zero_run;
    end
  end

  assign w_lit = enable & w_cur_en & (r_slot_cnt >= c_dead) & (r_pwm_cnt <= brightness);

  always_comb begin
    w_an_nxt   = '1;
    w_sseg_nxt = c_seg_blank;
    w_dp_nxt   = 1'b1;
    if (w_lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_idx == c_idx_w'(i)) begin
          w_an_nxt[i] = 1'b0;
        end
      end
      w_sseg_nxt = w_cur_blank ? c_seg_blank : seg_decode(w_cur_nib);
      w_dp_nxt   = ~w_cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_cnt      <= '0;
      r_pwm_cnt       <= '0;
      r_idx           <= '0;
      r_snap_digits   <= '0;
      r_snap_dp       <= '0;
      r_snap_en       <= '0;
      r_snap_blank_lz <= 1'b0;
      r_sseg          <= c_seg_blank;
      r_dp            <= 1'b1;
      r_an            <= '1;
      r_frame_tick    <= 1'b0;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + c_slot_one;
      r_pwm_cnt  <= w_slot_wrap ? '0 : r_pwm_cnt + c_pwm_one;
      if (w_slot_wrap) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_one;
      end
      r_frame_tick <= w_frame_wrap;
      // Content is latched only at frame boundaries so a frame never tears
      if (w_frame_wrap) begin
        r_snap_digits   <= digits;
        r_snap_dp       <= dp_in;
        r_snap_en       <= digit_en;
        r_snap_blank_lz <= blank_lz;
      end
      r_sseg <= w_sseg_nxt;
      r_dp   <= w_dp_nxt;
      r_an   <= w_an_nxt;
    end
  end

  assign sseg       = r_sseg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_driver
// Purpose  : Directed self-checking bench for sseg_scan_driver (4 digits, 8-cycle slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DB = 2;
  localparam int DC = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] digit_en;
  logic          blank_lz;
  logic [DB-1:0] brightness;
  logic [6:0]    sseg;
  logic          dp;
  logic [ND-1:0] an;
  logic          frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  sseg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DIM_BITS(DB), .DEAD_CYC(DC)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
    .dp_in(dp_in), .digit_en(digit_en), .blank_lz(blank_lz),
    .brightness(brightness), .sseg(sseg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to the next frame_tick sample (state: idx 0, slot 0)
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    check_eq("frame_sync", 32'(seen), 32'd1);
  endtask

  // Cycles until frame_tick is seen (-1 if never within the budget)
  task automatic cycles_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      tick(1);
      if (frame_tick === 1'b1) n = i;
    end
  endtask

  // Called at a frame_tick sample; checks all 32 slot positions of the frame.
  // Output visible at sample p+1 belongs to frame position p.
  task automatic run_frame(input string tag, input logic [27:0] seg_exp,
                           input logic [3:0] dp_exp, input logic [7:0] slot_mask,
                           input logic [3:0] en_mask, input int chg_p,
                           input logic [15:0] chg_digits);
    int         idx;
    int         slot;
    logic       lit;
    logic [3:0] an_e;
    logic [6:0] sseg_e;
    logic       dp_e;
    for (int p = 0; p < 32; p++) begin
      if (p == chg_p) digits = chg_digits;
      tick(1);
      idx    = p / 8;
      slot   = p % 8;
      lit    = en_mask[idx] & slot_mask[slot];
      an_e   = 4'hF;
      sseg_e = 7'h7F;
      dp_e   = 1'b1;
      if (lit) begin
        an_e[idx] = 1'b0;
        sseg_e    = seg_exp[7*idx +: 7];
        dp_e      = dp_exp[idx];
      end
      check_eq(tag, 32'({an, sseg, dp}), 32'({an_e, sseg_e, dp_e}));
      check_eq({tag, "_ft"}, 32'(frame_tick), 32'(p == 31));
    end
  endtask

  localparam logic [27:0] SEG_12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [27:0] SEG_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
  localparam logic [27:0] SEG_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] SEG_1111 = {7'h79, 7'h79, 7'h79, 7'h79};
  localparam logic [27:0] SEG_2222 = {7'h24, 7'h24, 7'h24, 7'h24};

  initial begin
    int   n;
    logic dark_bad;

    rst_n      = 1'b0;
    enable     = 1'b1;
    digits     = 16'h12AF;
    dp_in      = 4'h0;
    digit_en   = 4'hF;
    blank_lz   = 1'b0;
    brightness = 2'd3;

    // Reset and first (dark) frame
    tick(3);
    check_eq("rst_out", 32'({an, sseg, dp}), 32'h0000_0FFF);
    check_eq("rst_ft", 32'(frame_tick), 32'd0);
    rst_n    = 1'b1;
    n        = -1;
    dark_bad = 1'b0;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      tick(1);
      if (an !== 4'hF) dark_bad = 1'b1;
      if (frame_tick === 1'b1) n = i;
    end
    check_eq("first_tick", 32'(n), 32'd32);
    check_eq("first_dark", 32'(dark_bad), 32'd0);

    // Plain scan at full brightness
    run_frame("scan", SEG_12AF, 4'hF, 8'hFE, 4'hF, -1, 16'h0);

    // Leading-zero blanking, dp still shown on a blanked digit
    blank_lz = 1'b1;
    digits   = 16'h0050;
    dp_in    = 4'b0101;
    wait_frame();
    run_frame("blank", SEG_0050, 4'b1010, 8'hFE, 4'hF, -1, 16'h0);
    digits = 16'h0000;
    dp_in  = 4'h0;
    wait_frame();
    run_frame("zero", SEG_0000, 4'hF, 8'hFE, 4'hF, -1, 16'h0);

    // PWM duty at each brightness step
    blank_lz = 1'b0;
    digits   = 16'h12AF;
    wait_frame();
    brightness = 2'd0;
    run_frame("pwm0", SEG_12AF, 4'hF, 8'h10, 4'hF, -1, 16'h0);
    brightness = 2'd1;
    run_frame("pwm1", SEG_12AF, 4'hF, 8'h32, 4'hF, -1, 16'h0);
    brightness = 2'd2;
    run_frame("pwm2", SEG_12AF, 4'hF, 8'h76, 4'hF, -1, 16'h0);
    brightness = 2'd3;

    // Mid-frame content change waits for the next frame
    digits = 16'h1111;
    wait_frame();
    run_frame("snap_old", SEG_1111, 4'hF, 8'hFE, 4'hF, 16, 16'h2222);
    run_frame("snap_new", SEG_2222, 4'hF, 8'hFE, 4'hF, -1, 16'h0);

    // Per-digit enable
    digit_en = 4'b1011;
    wait_frame();
    run_frame("digit_en", SEG_2222, 4'hF, 8'hFE, 4'b1011, -1, 16'h0);

    // Global enable acts immediately, frame timing unaffected
    digit_en = 4'hF;
    wait_frame();
    tick(10);
    check_eq("en_before", 32'({an, sseg, dp}), 32'({4'hD, 7'h24, 1'b1}));
    enable = 1'b0;
    tick(1);
    check_eq("en_dark", 32'({an, sseg, dp}), 32'h0000_0FFF);
    cycles_to_tick(n);
    check_eq("en_tick_gap", 32'(n), 32'd21);
    run_frame("disabled", SEG_2222, 4'hF, 8'hFE, 4'h0, -1, 16'h0);
    enable = 1'b1;

    // Mid-frame reset restarts the scan
    wait_frame();
    tick(13);
    rst_n = 1'b0;
    tick(1);
    check_eq("midrst_out", 32'({an, sseg, dp}), 32'h0000_0FFF);
    check_eq("midrst_ft", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    cycles_to_tick(n);
    check_eq("midrst_tick", 32'(n), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
